os_array_ctrl: RTL and testbench

//  Sequencer for an NxN output-stationary PE array (OSPE grid). Per job: clears PE accumulators,

---
 rtl/os_array_ctrl.sv | 172 +++++++++++++++++
 tb/tb_os_array_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_array_ctrl.sv
// Sequencer for an NxN output-stationary PE array: clear, skewed feed, drain, row readout.
// Optional abort path enabled by defining OS_CTRL_ABORT_EN.
module os_array_ctrl #(
    parameter int N      = 4,
    parameter int KW     = 8,
    parameter int PE_LAT = 1,
    localparam int CW    = KW + 1,
    localparam int RW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [KW-1:0] k_len,
`ifdef OS_CTRL_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] step,
    output logic [N-1:0]  a_lane_en,
    output logic [N-1:0]  b_lane_en,
    output logic          pe_rstn_pipe,
    output logic          pe_rstn_psum,
    output logic          res_valid,
    output logic [RW-1:0] res_row,
    input  logic          res_ready
);

    localparam int DW = $clog2(N + PE_LAT);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        READ,
`ifdef OS_CTRL_ABORT_EN
        ABORT,
`endif
        DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] kLat;
    logic [DW-1:0] drainCnt;
    logic [N-1:0]  laneEn;
    logic [CW-1:0] feedLast;

    assign feedLast  = CW'(kLat) + CW'(N - 2);
    assign a_lane_en = laneEn;
    assign b_lane_en = laneEn;

    // Lane i sees operand index t-i, valid while 0 <= t-i < k.
    function automatic logic [N-1:0] laneMask(
        input logic [CW-1:0] t,
        input logic [KW-1:0] k
    );
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (int'(t) >= i) && (int'(t) < i + int'(k));
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            kLat         <= '0;
            drainCnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            step         <= '0;
            laneEn       <= '0;
            pe_rstn_pipe <= 1'b0;
            pe_rstn_psum <= 1'b0;
            res_valid    <= 1'b0;
            res_row      <= '0;
`ifdef OS_CTRL_ABORT_EN
            aborted      <= 1'b0;
        end else if (abort && state != IDLE &&
                     state != DONE && state != ABORT) begin
            state        <= ABORT;
            step         <= '0;
            laneEn       <= '0;
            pe_rstn_pipe <= 1'b0;
            pe_rstn_psum <= 1'b0;
            res_valid    <= 1'b0;
            res_row      <= '0;
            aborted      <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    pe_rstn_pipe <= 1'b0;
                    pe_rstn_psum <= 1'b1;
                    if (start) begin
                        state        <= CLEAR;
                        kLat         <= k_len;
                        busy         <= 1'b1;
                        pe_rstn_psum <= 1'b0;
                    end
                end
                CLEAR: begin
                    pe_rstn_psum <= 1'b1;
                    if (kLat == '0) begin
                        state     <= READ;
                        res_valid <= 1'b1;
                        res_row   <= '0;
                    end else begin
                        state        <= FEED;
                        pe_rstn_pipe <= 1'b1;
                        step         <= '0;
                        laneEn       <= laneMask('0, kLat);
                    end
                end
                FEED: begin
                    if (step == feedLast) begin
                        state    <= DRAIN;
                        step     <= '0;
                        laneEn   <= '0;
                        drainCnt <= '0;
                    end else begin
                        step   <= step + CW'(1);
                        laneEn <= laneMask(step + CW'(1), kLat);
                    end
                end
                DRAIN: begin
                    if (drainCnt == DW'(N - 2 + PE_LAT)) begin
                        state        <= READ;
                        pe_rstn_pipe <= 1'b0;
                        res_valid    <= 1'b1;
                        res_row      <= '0;
                    end else begin
                        drainCnt <= drainCnt + DW'(1);
                    end
                end
                READ: begin
                    if (res_ready) begin
                        if (res_row == RW'(N - 1)) begin
                            state     <= DONE;
                            res_valid <= 1'b0;
                            res_row   <= '0;
                            done      <= 1'b1;
                        end else begin
                            res_row <= res_row + RW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
`ifdef OS_CTRL_ABORT_EN
                ABORT: begin
                    state        <= IDLE;
                    aborted      <= 1'b0;
                    busy         <= 1'b0;
                    pe_rstn_psum <= 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_os_array_ctrl.sv
// Self-checking bench for os_array_ctrl: job-timeline model plus directed literals.
// Abort scenarios are exercised when OS_CTRL_ABORT_EN is defined.
module tb_os_array_ctrl;

    localparam int N      = 4;
    localparam int KW     = 8;
    localparam int PE_LAT = 1;
    localparam int CW     = KW + 1;
    localparam int RW     = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          res_ready = 1'b0;
    logic          busy, done, pe_rstn_pipe, pe_rstn_psum, res_valid;
    logic [CW-1:0] step;
    logic [N-1:0]  a_lane_en, b_lane_en;
    logic [RW-1:0] res_row;
    logic          abortIn;
    logic          abortedOut;

`ifdef OS_CTRL_ABORT_EN
    logic abort = 1'b0;
    logic aborted;
    assign abortIn    = abort;
    assign abortedOut = aborted;
`else
    assign abortIn    = 1'b0;
    assign abortedOut = 1'b0;
`endif

    os_array_ctrl #(.N(N), .KW(KW), .PE_LAT(PE_LAT)) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .k_len(k_len),
`ifdef OS_CTRL_ABORT_EN
        .abort(abort),
        .aborted(aborted),
`endif
        .busy(busy),
        .done(done),
        .step(step),
        .a_lane_en(a_lane_en),
        .b_lane_en(b_lane_en),
        .pe_rstn_pipe(pe_rstn_pipe),
        .pe_rstn_psum(pe_rstn_psum),
        .res_valid(res_valid),
        .res_row(res_row),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Job timeline: cycle 1 of a job is the clear, then k+N-1 feed
    // cycles and N-1+PE_LAT drain cycles, then row readout.
    typedef enum {M_IDLE, M_JOB, M_DONE, M_ABORT} mmode_t;
    mmode_t mMode = M_IDLE;
    int     mC = 0, mK = 0, mR = 0;
    bit     mRst = 1'b1;

    function automatic int preLen(input int k);
        return (k == 0) ? 1 : 1 + (k + N - 1) + (N - 1 + PE_LAT);
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            mMode = M_IDLE;
            mRst  = 1'b1;
        end else begin
            mRst = 1'b0;
            case (mMode)
                M_IDLE: if (start) begin
                    mMode = M_JOB;
                    mC    = 1;
                    mK    = int'(k_len);
                    mR    = 0;
                end
                M_JOB: begin
                    if (abortIn) mMode = M_ABORT;
                    else if (mC <= preLen(mK)) mC++;
                    else if (res_ready) begin
                        if (mR == N - 1) mMode = M_DONE;
                        else mR++;
                    end
                end
                default: mMode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic          eBusy, eDone, ePipe, ePsum, eValid, eAb;
        logic [CW-1:0] eStep;
        logic [N-1:0]  eLane;
        logic [RW-1:0] eRow;
        int            t;
        eBusy  = (mMode != M_IDLE);
        eDone  = (mMode == M_DONE);
        eAb    = (mMode == M_ABORT);
        eStep  = '0;
        eLane  = '0;
        ePipe  = 1'b0;
        ePsum  = 1'b1;
        eValid = 1'b0;
        eRow   = '0;
        if (mMode == M_IDLE) ePsum = !mRst;
        else if (mMode == M_ABORT) ePsum = 1'b0;
        else if (mMode == M_JOB) begin
            if (mC == 1) ePsum = 1'b0;
            else if (mC <= preLen(mK)) begin
                ePipe = 1'b1;
                t = mC - 2;
                if (t < mK + N - 1) begin
                    eStep = CW'(t);
                    for (int i = 0; i < N; i++)
                        eLane[i] = (t >= i) && (t < i + mK);
                end
            end else begin
                eValid = 1'b1;
                eRow   = RW'(mR);
            end
        end
        chk("busy", busy, eBusy);
        chk("done", done, eDone);
        chk("step", step, eStep);
        chk("a_lane_en", a_lane_en, eLane);
        chk("b_lane_en", b_lane_en, eLane);
        chk("pe_rstn_pipe", pe_rstn_pipe, ePipe);
        chk("pe_rstn_psum", pe_rstn_psum, ePsum);
        chk("res_valid", res_valid, eValid);
        chk("res_row", res_row, eRow);
        chk("aborted", abortedOut, eAb);
    end

    logic [N-1:0] lanes2 [6] = '{4'b0001, 4'b0011, 4'b0111,
                                 4'b1110, 4'b1100, 4'b1000};

    task automatic kick(input int k);
        k_len = KW'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_psum", pe_rstn_psum, 0);
        chk("rst_pipe", pe_rstn_pipe, 0);
        chk("rst_valid", res_valid, 0);
        rstn = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);

        kick(3);
        for (int n = 1; n <= 16; n++) begin
            if (n == 1) chk("t2_clear_psum", pe_rstn_psum, 0);
            if (n >= 2 && n <= 7) begin
                chk("t2_lane", a_lane_en, lanes2[n-2]);
                chk("t2_step", step, n - 2);
            end
            if (n == 11) chk("t2_drain_pipe", pe_rstn_pipe, 1);
            if (n >= 12 && n <= 15)
                chk("t2_row", {res_valid, res_row}, {1'b1, RW'(n - 12)});
            if (n == 16) chk("t2_done", done, 1);
            @(negedge clk);
        end

        kick(3);
        for (int n = 1; n <= 19; n++) begin
            res_ready = !(n >= 12 && n <= 14);
            if (n >= 12 && n <= 14)
                chk("t3_hold", {res_valid, res_row}, {1'b1, 2'd0});
            if (n >= 15 && n <= 18)
                chk("t3_row", {res_valid, res_row}, {1'b1, RW'(n - 15)});
            if (n == 19) chk("t3_done", done, 1);
            @(negedge clk);
        end
        res_ready = 1'b1;

        kick(0);
        for (int n = 1; n <= 6; n++) begin
            if (n >= 2 && n <= 5)
                chk("t4_row", {res_valid, res_row}, {1'b1, RW'(n - 2)});
            if (n == 6) chk("t4_done", done, 1);
            @(negedge clk);
        end

        kick(5);
        for (int n = 1; n <= 18; n++) begin
            start = (n == 3 || n == 15);
            k_len = 8'd200;
            if (n == 18) chk("t5_done", done, 1);
            @(negedge clk);
        end
        start = 1'b0;
        kick(2);
        for (int n = 1; n <= 15; n++) begin
            if (n == 15) chk("t5_done2", done, 1);
            @(negedge clk);
        end

        kick(3);
        repeat (3) @(negedge clk);
        chk("t6_step2", step, 2);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_lane", a_lane_en, 0);
        rstn = 1'b1;
        @(negedge clk);

`ifdef OS_CTRL_ABORT_EN
        kick(3);
        repeat (8) @(negedge clk);
        chk("t6_in_drain", {pe_rstn_pipe, a_lane_en}, {1'b1, 4'b0000});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_aborted", {aborted, pe_rstn_pipe, pe_rstn_psum}, 3'b100);
        @(negedge clk);
        chk("t6_ab_idle", {busy, done, aborted}, 3'b000);
        @(negedge clk);
`endif

        for (int c = 0; c < 4000; c++) begin
            start = ($urandom % 6) == 0;
            if ($urandom % 16 == 0) k_len = KW'($urandom_range(0, 255));
            else k_len = KW'($urandom_range(0, 9));
            res_ready = ($urandom % 3) != 0;
            rstn = ($urandom % 700) != 0;
`ifdef OS_CTRL_ABORT_EN
            abort = ($urandom % 50) == 0;
`endif
            @(negedge clk);
        end
        start = 1'b0;
        rstn = 1'b1;
`ifdef OS_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
